// File: rtl/e_mdu_ctrl_if.sv
// rtl/e_mdu_ctrl_if.sv - E-stage multiply/divide request and HI/LO result bundle
interface e_mdu_ctrl_if;
  logic [3:0]  E_md_op;
  logic        E_start;
  logic [31:0] E_data1;
  logic [31:0] E_data2;
  logic        D_is_md;
  logic [31:0] E_md_out;
  logic        E_busy;
  logic [31:0] E_hi;
  logic [31:0] E_lo;
  logic        D_md_stall;

  // Pipeline side: issues ops and observes HI/LO, busy and stall
  modport master (
    output E_md_op, E_start, E_data1, E_data2, D_is_md,
    input  E_md_out, E_busy, E_hi, E_lo, D_md_stall
  );

  // Multiply/divide unit side
  modport slave (
    input  E_md_op, E_start, E_data1, E_data2, D_is_md,
    output E_md_out, E_busy, E_hi, E_lo, D_md_stall
  );
endinterface

// File: rtl/e_mdu_ctrl.sv
// rtl/e_mdu_ctrl.sv - E-stage mult/div sequencer with HI/LO, busy counter and D-stage stall; MDU_MADD_EN adds MADD/MADDU
module e_mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  e_mdu_ctrl_if.slave md
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
`endif

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_phi;
  logic [31:0] r_plo;
  logic        r_busy;

  logic        w_launch;
  logic [3:0]  w_cycles;
  logic [63:0] w_a_sx;
  logic [63:0] w_b_sx;
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [31:0] w_div_b_s;
  logic [31:0] w_div_b_u;
  logic [31:0] w_sq_mag;
  logic [31:0] w_sr_mag;
  logic [31:0] w_sq;
  logic [31:0] w_sr;
  logic [31:0] w_uq;
  logic [31:0] w_ur;
  logic [63:0] w_next;

  // Low 64 bits of a 64x64 product of sign-extended operands equal the signed 32x32 product
  assign w_a_sx   = {{32{md.E_data1[31]}}, md.E_data1};
  assign w_b_sx   = {{32{md.E_data2[31]}}, md.E_data2};
  assign w_prod_s = w_a_sx * w_b_sx;
  assign w_prod_u = {32'd0, md.E_data1} * {32'd0, md.E_data2};

  // Signed divide on magnitudes: avoids the 0x80000000 / -1 overflow and gives
  // truncation toward zero with the remainder following the dividend's sign.
  // Zero divisors are steered to 1 only to keep the divider defined; the result is discarded.
  assign w_abs_a   = md.E_data1[31] ? (~md.E_data1 + 32'd1) : md.E_data1;
  assign w_abs_b   = md.E_data2[31] ? (~md.E_data2 + 32'd1) : md.E_data2;
  assign w_div_b_s = (w_abs_b == 32'd0) ? 32'd1 : w_abs_b;
  assign w_div_b_u = (md.E_data2 == 32'd0) ? 32'd1 : md.E_data2;
  assign w_sq_mag  = w_abs_a / w_div_b_s;
  assign w_sr_mag  = w_abs_a % w_div_b_s;
  assign w_sq      = (md.E_data1[31] ^ md.E_data2[31]) ? (~w_sq_mag + 32'd1) : w_sq_mag;
  assign w_sr      = md.E_data1[31] ? (~w_sr_mag + 32'd1) : w_sr_mag;
  assign w_uq      = md.E_data1 / w_div_b_u;
  assign w_ur      = md.E_data1 % w_div_b_u;

  assign w_cycles = (md.E_md_op == OP_DIV || md.E_md_op == OP_DIVU) ?
                    4'(DIV_CYCLES) : 4'(MULT_CYCLES);

  // Decide whether this cycle's start pulse launches an operation
  always_comb begin
    w_launch = 1'b0;
    if (md.E_start && r_state == S_IDLE) begin
      case (md.E_md_op)
        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: w_launch = 1'b1;
`ifdef MDU_MADD_EN
        OP_MADD, OP_MADDU:                  w_launch = 1'b1;
`endif
        default:                            w_launch = 1'b0;
      endcase
    end
  end

  // Result to park in the pending registers; divide by zero keeps current HI/LO
  always_comb begin
    w_next = {r_hi, r_lo};
    case (md.E_md_op)
      OP_MULT:  w_next = w_prod_s;
      OP_MULTU: w_next = w_prod_u;
      OP_DIV:   if (md.E_data2 != 32'd0) w_next = {w_sr, w_sq};
      OP_DIVU:  if (md.E_data2 != 32'd0) w_next = {w_ur, w_uq};
`ifdef MDU_MADD_EN
      OP_MADD:  w_next = {r_hi, r_lo} + w_prod_s;
      OP_MADDU: w_next = {r_hi, r_lo} + w_prod_u;
`endif
      default:  w_next = {r_hi, r_lo};
    endcase
  end

  // Sequencer: launch, count down the latency, commit pending HI/LO, serve MTHI/MTLO when idle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_phi   <= 32'd0;
      r_plo   <= 32'd0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            {r_phi, r_plo} <= w_next;
            r_cnt          <= w_cycles;
            r_state        <= S_RUN;
            r_busy         <= 1'b1;
          end else if (!md.E_start && md.E_md_op == OP_MTHI) begin
            r_hi <= md.E_data1;
          end else if (!md.E_start && md.E_md_op == OP_MTLO) begin
            r_lo <= md.E_data1;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_hi    <= r_phi;
            r_lo    <= r_plo;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign md.E_busy     = r_busy;
  assign md.E_hi       = r_hi;
  assign md.E_lo       = r_lo;
  assign md.E_md_out   = (md.E_md_op == OP_MFHI) ? r_hi :
                         (md.E_md_op == OP_MFLO) ? r_lo : 32'd0;
  assign md.D_md_stall = md.D_is_md && (md.E_start || r_busy);

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// tb/tb_e_mdu_ctrl.sv - randomized self-checking bench for e_mdu_ctrl against an arithmetic HI/LO model
module tb_e_mdu_ctrl;
  logic clk = 1'b0;
  logic reset_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  e_mdu_ctrl_if bus();

  e_mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .md      (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_launch(input logic [3:0] op);
    if (op >= 4'd1 && op <= 4'd4) return 1'b1;
`ifdef MDU_MADD_EN
    if (op == 4'd9 || op == 4'd10) return 1'b1;
`endif
    return 1'b0;
  endfunction

  // {HI,LO} after a launch op, computed with 64-bit integer arithmetic
  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] hi, input logic [31:0] lo);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    logic [63:0]     acc;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    acc = {hi, lo};
    case (op)
      4'd1: return sa * sb;
      4'd2: return ua * ub;
      4'd3: begin
        if (b == 32'd0) return acc;
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      4'd4: begin
        if (b == 32'd0) return acc;
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      4'd9:    return acc + 64'(sa * sb);
      4'd10:   return acc + 64'(ua * ub);
      default: return acc;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issue one start pulse; disturb: 0 none, 1 second start mid-run, 2 MTHI mid-run
  task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit dmd, input int disturb, input string tag);
    logic [63:0] exp;
    int          n;
    int          k;
    bit          go;
    go  = is_launch(op);
    exp = go ? model(op, a, b, m_hi, m_lo) : {m_hi, m_lo};
    n   = (op == 4'd3 || op == 4'd4) ? 10 : 5;
    @(negedge clk);
    bus.E_md_op = op;
    bus.E_data1 = a;
    bus.E_data2 = b;
    bus.E_start = 1'b1;
    bus.D_is_md = dmd;
    #1;
    check({tag, "_stall_start"}, 64'(bus.D_md_stall), 64'(dmd));
    check({tag, "_mdout_start"}, 64'(bus.E_md_out),
          (op == 4'd5) ? 64'(m_hi) : (op == 4'd6) ? 64'(m_lo) : 64'd0);
    @(negedge clk);
    bus.E_start = 1'b0;
    bus.E_md_op = 4'd0;
    k = 0;
    while (bus.E_busy && k < 40) begin
      check({tag, "_stall_busy"}, 64'(bus.D_md_stall), 64'(dmd));
      check({tag, "_hold"}, {bus.E_hi, bus.E_lo}, {m_hi, m_lo});
      k++;
      if (disturb == 1 && k == 2) begin
        bus.E_md_op = 4'd1;
        bus.E_data1 = $urandom;
        bus.E_data2 = $urandom;
        bus.E_start = 1'b1;
      end else if (disturb == 2 && k == 2) begin
        bus.E_md_op = 4'd7;
        bus.E_data1 = 32'h1234;
        bus.E_start = 1'b0;
      end else begin
        bus.E_md_op = 4'd0;
        bus.E_start = 1'b0;
      end
      @(negedge clk);
    end
    bus.E_md_op = 4'd0;
    bus.E_start = 1'b0;
    #1;
    check({tag, "_cycles"}, 64'(k), go ? 64'(n) : 64'd0);
    check({tag, "_stall_after"}, 64'(bus.D_md_stall), 64'd0);
    {m_hi, m_lo} = exp;
    check({tag, "_hilo"}, {bus.E_hi, bus.E_lo}, exp);
  endtask

  task automatic mt(input bit to_hi, input logic [31:0] v, input string tag);
    @(negedge clk);
    bus.E_md_op = to_hi ? 4'd7 : 4'd8;
    bus.E_data1 = v;
    bus.E_start = 1'b0;
    bus.D_is_md = 1'b0;
    @(negedge clk);
    bus.E_md_op = 4'd0;
    if (to_hi) m_hi = v;
    else       m_lo = v;
    check({tag, "_hilo"}, {bus.E_hi, bus.E_lo}, {m_hi, m_lo});
    bus.E_md_op = to_hi ? 4'd5 : 4'd6;
    #1;
    check({tag, "_mf"}, 64'(bus.E_md_out), 64'(v));
    bus.E_md_op = 4'd0;
  endtask

  initial begin
    reset_n     = 1'b0;
    bus.E_md_op = 4'd1;
    bus.E_start = 1'b0;
    bus.E_data1 = $urandom;
    bus.E_data2 = $urandom;
    bus.D_is_md = 1'b1;
    m_hi = 32'd0;
    m_lo = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_hilo", {bus.E_hi, bus.E_lo}, 64'd0);
    check("rst_busy", 64'(bus.E_busy), 64'd0);
    check("rst_stall", 64'(bus.D_md_stall), 64'd0);
    reset_n     = 1'b1;
    bus.E_md_op = 4'd5;
    bus.D_is_md = 1'b0;
    #1;
    check("rst_mfhi", 64'(bus.E_md_out), 64'd0);
    bus.E_md_op = 4'd0;

    launch(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b1, 0, "mult");
    check("mult_const", {bus.E_hi, bus.E_lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    launch(4'd2, 32'hFFFF_FFFE, 32'd3, 1'b0, 0, "multu");
    check("multu_const", {bus.E_hi, bus.E_lo}, 64'h0000_0002_FFFF_FFFA);
    launch(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b1, 0, "div");
    check("div_const", {bus.E_hi, bus.E_lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    launch(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, "div_ovf");
    check("div_ovf_const", {bus.E_hi, bus.E_lo}, 64'h0000_0000_8000_0000);
    mt(1'b1, 32'h0000_0077, "pre_dz");
    launch(4'd4, 32'h1234_5678, 32'd0, 1'b0, 0, "divu_zero");
    launch(4'd3, 32'h1234_5678, 32'd0, 1'b0, 0, "div_zero");
    launch(4'd1, 32'd7, 32'd9, 1'b1, 1, "restart");
    launch(4'd2, 32'd11, 32'd13, 1'b1, 2, "mthi_run");
    mt(1'b0, 32'hDEAD_BEEF, "mtlo");
    mt(1'b1, 32'h0000_0005, "mthi");
    for (int i = 0; i < 9; i++) launch(4'(5 + i % 6 == 4'd0 ? 0 : 5 + i % 6), $urandom, $urandom, 1'b0, 0, "ignored");

`ifdef MDU_MADD_EN
    mt(1'b1, 32'd0, "madd_hi");
    mt(1'b0, 32'hFFFF_FFFF, "madd_lo");
    launch(4'd10, 32'd1, 32'd1, 1'b1, 0, "maddu");
    check("maddu_const", {bus.E_hi, bus.E_lo}, 64'h0000_0001_0000_0000);
    launch(4'd9, 32'hFFFF_FFFF, 32'd5, 1'b0, 0, "madd");
`else
    launch(4'd9, 32'd3, 32'd4, 1'b1, 0, "op9_off");
    launch(4'd10, 32'd3, 32'd4, 1'b0, 0, "op10_off");
`endif

    // Reset in the middle of a divide aborts it and clears HI/LO
    @(negedge clk);
    bus.E_md_op = 4'd3;
    bus.E_data1 = 32'd100;
    bus.E_data2 = 32'd7;
    bus.E_start = 1'b1;
    @(negedge clk);
    bus.E_start = 1'b0;
    bus.E_md_op = 4'd0;
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("arst_busy", 64'(bus.E_busy), 64'd0);
    check("arst_hilo", {bus.E_hi, bus.E_lo}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    m_hi = 32'd0;
    m_lo = 32'd0;
    repeat (12) @(negedge clk);
    check("arst_nocommit", {bus.E_hi, bus.E_lo}, 64'd0);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) < 2) begin
        mt(1'($urandom_range(0, 1)), $urandom, "rnd_mt");
      end else begin
        launch(4'($urandom_range(0, 10)), pick(), pick(), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 2)), "rnd");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
